db_ecc_arbiter: RTL and testbench
=================================

Name: db_ecc_arbiter

Overview:
- Clocked round-robin arbiter that shares one Hamming(7,4) correction / data-bucket unit between NREQ router-side requesters.
- Each requester offers an 11-bit raw packet. The arbiter picks one, drives it to the shared decoder, and waits for the decoder's completion and syndrome.
- It returns completion to the winning requester and keeps saturating statistics of corrected and timed-out packets.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 11, raw packet width.
- CNT_W, 8, width of the statistics counters.
- TIMEOUT, 15, maximum cycles allowed in WAIT for dec_done before abort.

Ports:
- clk  in  1  single system clock, rising edge.
- _RESET  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i holds a packet.
- req_data  in  NREQ*DW  packet of requester i in bits [i*DW +: DW].
- req_ack  out  NREQ  one-cycle pulse to requester i when its packet is done (decoded or aborted).
- dec_valid  out  1  packet offered to the decoder.
- dec_data  out  DW  registered copy of the granted packet.
- dec_ready  in  1  decoder accepts dec_data when dec_valid && dec_ready.
- dec_done  in  1  decoder finished the current packet.
- dec_syn  in  3  syndrome reported with dec_done; nonzero means 1 bit was corrected.
- grant_id  out  $clog2(NREQ)  index of the current or last grantee.
- busy  out  1  FSM not in IDLE.
- corr_cnt  out  CNT_W  saturating count of packets with nonzero syndrome.
- tmo_cnt  out  CNT_W  saturating count of timeouts.
- stat_clr  in  1  synchronous clear of both counters.

Behaviour:
- Reset (while _RESET=0, asynchronous):
  - FSM=IDLE; dec_valid=0, dec_data=0, req_ack=0, grant_id=0, busy=0, corr_cnt=0, tmo_cnt=0.
  - Round-robin pointer rr=0.
- Reset mid-transaction:
  - The in-flight packet is dropped and no req_ack is issued.
  - The requester must re-present its packet after reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is high, grant the first requester at or after rr (cyclic search) and move to ISSUE next cycle.
  - On that edge, latch its data into dec_data and its index into grant_id.
  - With no request, stay in IDLE.
- ISSUE:
  - dec_valid=1; dec_data is held stable.
  - On dec_valid && dec_ready: go to WAIT next cycle, deassert dec_valid, clear the wait counter.
- WAIT:
  - Wait counter increments each cycle.
  - On dec_done: pulse req_ack[grant_id] for 1 cycle, set rr=grant_id+1 mod NREQ, and return to IDLE.
  - If dec_syn!=0 on that cycle, corr_cnt increments, saturating at 2^CNT_W-1.
  - If the counter reaches TIMEOUT without dec_done: increment tmo_cnt (saturating), pulse req_ack[grant_id], advance rr the same way, and return to IDLE.
- dec_done outside WAIT is ignored.
- Latency, request-to-issue: 1 cycle from req_valid sampled in IDLE to dec_valid=1.
- Minimum turnaround: IDLE, then ISSUE with dec_ready=1, then WAIT with dec_done=1, then IDLE. This is 3 cycles per packet; back-to-back grants start in the cycle after req_ack.
- Fairness:
  - The granted requester has lowest priority for the next grant.
  - With all NREQ requesting continuously, grants cycle 0,1,2,...,NREQ-1,0.
- Requester contract:
  - req_valid and req_data are held until req_ack.
  - Deassertion of req_valid before grant is legal. After grant, the latched copy is used.
- stat_clr:
  - Synchronous clear of both counters.
  - Clear has priority over a same-cycle increment.
- req_ack is one-hot or zero every cycle.
- busy = (state != IDLE).

Test Plan:
- Reset: hold _RESET=0 with all req_valid=1 -> all outputs 0; release -> grant_id=0, dec_valid=1 one cycle later with dec_data=req_data[0].
- Round-robin: all 4 requesters valid continuously, dec_ready=1, dec_done 1 cycle after accept, dec_syn=0 -> req_ack order 0,1,2,3,0; each packet takes 3 cycles; corr_cnt stays 0.
- Correction count: single requester 2 sends 3 packets, 11'h055, 11'h054, 11'h057, with dec_syn=0,1,3 -> corr_cnt=2, three req_ack[2] pulses.
- Backpressure and stability: dec_ready=0 for 5 cycles in ISSUE -> dec_valid held 1, dec_data unchanged; then dec_ready=1 -> WAIT entered next cycle.
- Timeout: dec_done never asserted -> after 15 WAIT cycles, tmo_cnt=1 and req_ack pulses once; a late dec_done in IDLE is ignored and does not change corr_cnt.
- Saturation, clear and mid-operation reset:
  - Force 260 corrected packets -> corr_cnt=255.
  - stat_clr with a simultaneous dec_done and dec_syn=5 -> corr_cnt=0.
  - _RESET pulsed low during WAIT -> no req_ack, FSM in IDLE.

Source files
------------

// File: rtl/db_ecc_arbiter.sv
// ---------------------------------------------------------------------------
// db_ecc_arbiter
//   Round-robin arbiter sharing one Hamming(7,4) correction / data-bucket
//   decoder between NREQ requesters. The chosen packet is latched, offered to
//   the decoder, and the arbiter then waits (bounded by TIMEOUT) for
//   completion. Saturating statistics count corrected and timed-out packets.
//
// Ports
//   clk        system clock, rising edge
//   _RESET     asynchronous active-low reset
//   req_valid  [NREQ]      requester i holds a packet
//   req_data   [NREQ*DW]   packet i in bits [i*DW +: DW]
//   req_ack    [NREQ]      one-cycle done pulse to the grantee (one-hot or 0)
//   dec_valid  packet offered to decoder (ISSUE state)
//   dec_data   [DW]        latched copy of the granted packet
//   dec_ready  decoder accepts dec_data
//   dec_done   decoder finished current packet (ignored outside WAIT)
//   dec_syn    [3]         syndrome with dec_done, nonzero = corrected
//   grant_id   index of current / last grantee
//   busy       FSM not in IDLE
//   corr_cnt   saturating corrected-packet count
//   tmo_cnt    saturating timeout count
//   stat_clr   synchronous clear of both counters (wins over increment)
// ---------------------------------------------------------------------------
module db_ecc_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 11,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    _RESET,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ack,
    output logic                    dec_valid,
    output logic [DW-1:0]           dec_data,
    input  logic                    dec_ready,
    input  logic                    dec_done,
    input  logic [2:0]              dec_syn,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        corr_cnt,
    output logic [CNT_W-1:0]        tmo_cnt,
    input  logic                    stat_clr
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   pick;
    logic [IW:0]     cand;
    logic            any_req;
    logic [TW-1:0]   wcnt;
    logic            grant_go, accept, finish, timeout;

    // Cyclic search starting at rr; the extra bit in cand lets rr+i wrap
    // without overflow before folding back into 0..NREQ-1.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (!any_req && req_valid[cand[IW-1:0]]) begin
                any_req = 1'b1;
                pick    = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge _RESET) begin
        if (!_RESET) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    grant_go  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dec_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // dec_done on the last allowed cycle still counts as done
                if (dec_done) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ack = '0;
        if (finish) req_ack[grant_id] = 1'b1;
        dec_valid = (state == S_ISSUE);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge _RESET) begin
        if (!_RESET) begin
            dec_data <= '0;
            grant_id <= '0;
            rr       <= '0;
            wcnt     <= '0;
        end else begin
            if (grant_go) begin
                dec_data <= req_data[pick*DW +: DW];
                grant_id <= pick;
            end
            if (accept)
                wcnt <= '0;
            else if (state == S_WAIT)
                wcnt <= wcnt + TW'(1);
            // Grantee drops to lowest priority for the next search
            if (finish)
                rr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge _RESET) begin
        if (!_RESET) begin
            corr_cnt <= '0;
            tmo_cnt  <= '0;
        end else if (stat_clr) begin
            corr_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (finish && !timeout && (dec_syn != 3'd0) && (corr_cnt != '1))
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (timeout && (tmo_cnt != '1))
                tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_db_ecc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_db_ecc_arbiter
//   Directed, self-checking bench for db_ecc_arbiter (NREQ=4, DW=11).
//   Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_db_ecc_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 11;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ack;
    logic                 dec_valid;
    logic [DW-1:0]        dec_data;
    logic                 dec_ready;
    logic                 dec_done;
    logic [2:0]           dec_syn;
    logic [1:0]           grant_id;
    logic                 busy;
    logic [CNT_W-1:0]     corr_cnt;
    logic [CNT_W-1:0]     tmo_cnt;
    logic                 stat_clr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    db_ecc_arbiter #(.NREQ(NREQ), .DW(DW), .CNT_W(CNT_W), .TIMEOUT(15)) dut (
        .clk       (clk),
        ._RESET    (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .dec_valid (dec_valid),
        .dec_data  (dec_data),
        .dec_ready (dec_ready),
        .dec_done  (dec_done),
        .dec_syn   (dec_syn),
        .grant_id  (grant_id),
        .busy      (busy),
        .corr_cnt  (corr_cnt),
        .tmo_cnt   (tmo_cnt),
        .stat_clr  (stat_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        dec_ready = 1'b0;
        dec_done  = 1'b0;
        dec_syn   = 3'd0;
        stat_clr  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = {11'h444, 11'h333, 11'h222, 11'h111};
        dec_ready = 1'b0;
        dec_done  = 1'b0;
        dec_syn   = 3'd0;
        stat_clr  = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({dec_valid, busy, req_ack, grant_id} !== '0)
            $display("FAIL reset_ctrl: got valid=%0h busy=%0h ack=%0h gid=%0h expected all 0",
                     dec_valid, busy, req_ack, grant_id);
        else pass_cnt++;
        total_cnt++;
        if ({dec_data, corr_cnt, tmo_cnt} !== '0)
            $display("FAIL reset_data: got data=%0h corr=%0h tmo=%0h expected all 0",
                     dec_data, corr_cnt, tmo_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (dec_valid !== 1'b1 || grant_id !== 2'd0)
            $display("FAIL reset_first_grant: got valid=%0h gid=%0h expected valid=1 gid=0",
                     dec_valid, grant_id);
        else pass_cnt++;
        total_cnt++;
        if (dec_data !== 11'h111)
            $display("FAIL reset_first_data: got %0h expected 111", dec_data);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int ack_idx[$];
        int ack_cyc[$];
        int idx;
        do_reset();
        req_valid = 4'hF;
        req_data  = {11'h404, 11'h303, 11'h202, 11'h101};
        dec_ready = 1'b1;
        dec_done  = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                total_cnt++;
                if (!$onehot(req_ack))
                    $display("FAIL rr_onehot: got %0h expected one-hot", req_ack);
                else pass_cnt++;
                idx = 0;
                for (int j = 0; j < NREQ; j++) if (req_ack[j]) idx = j;
                ack_idx.push_back(idx);
                ack_cyc.push_back(c);
            end
        end
        total_cnt++;
        if (ack_idx.size() != 5)
            $display("FAIL rr_ack_count: got %0d expected 5", ack_idx.size());
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (k >= ack_idx.size())
                $display("FAIL rr_order_%0d: got none expected %0d", k, k % 4);
            else if (ack_idx[k] != k % 4 || ack_cyc[k] != 2 + 3 * k)
                $display("FAIL rr_order_%0d: got id=%0d cyc=%0d expected id=%0d cyc=%0d",
                         k, ack_idx[k], ack_cyc[k], k % 4, 2 + 3 * k);
            else pass_cnt++;
        end
        total_cnt++;
        if (corr_cnt !== 8'd0)
            $display("FAIL rr_corr: got %0d expected 0", corr_cnt);
        else pass_cnt++;
        req_valid = '0;
        dec_done  = 1'b0;
    endtask

    task automatic test_correction();
        logic [10:0] pk [3];
        logic [2:0]  sy [3];
        bit got;
        pk = '{11'h055, 11'h054, 11'h057};
        sy = '{3'd0, 3'd1, 3'd3};
        do_reset();
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = pk[0];
        dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                if (dec_valid) got = 1'b1;
            end
            total_cnt++;
            if (!got || dec_data !== pk[k] || grant_id !== 2'd2)
                $display("FAIL corr_issue_%0d: got valid=%0d data=%0h gid=%0h expected data=%0h gid=2",
                         k, got, dec_data, grant_id, pk[k]);
            else pass_cnt++;
            @(negedge clk);
            dec_done = 1'b1;
            dec_syn  = sy[k];
            #1;
            total_cnt++;
            if (req_ack !== 4'b0100)
                $display("FAIL corr_ack_%0d: got %0h expected 4", k, req_ack);
            else pass_cnt++;
            @(negedge clk);
            dec_done = 1'b0;
            dec_syn  = 3'd0;
            if (k < 2) req_data[2*DW +: DW] = pk[k+1];
        end
        req_valid = '0;
        total_cnt++;
        if (corr_cnt !== 8'd2 || tmo_cnt !== 8'd0)
            $display("FAIL corr_count: got corr=%0d tmo=%0d expected corr=2 tmo=0", corr_cnt, tmo_cnt);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0001;
        req_data[0 +: DW] = 11'h3A5;
        dec_ready = 1'b0;
        @(negedge clk);
        // Source changes after grant; the latched copy must stay on dec_data
        req_data[0 +: DW] = 11'h05A;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            total_cnt++;
            if (dec_valid !== 1'b1 || dec_data !== 11'h3A5)
                $display("FAIL bp_hold_%0d: got valid=%0h data=%0h expected valid=1 data=3a5",
                         c, dec_valid, dec_data);
            else pass_cnt++;
        end
        dec_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (dec_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL bp_wait: got valid=%0h busy=%0h expected valid=0 busy=1", dec_valid, busy);
        else pass_cnt++;
        dec_done = 1'b1;
        #1;
        total_cnt++;
        if (req_ack !== 4'b0001)
            $display("FAIL bp_ack: got %0h expected 1", req_ack);
        else pass_cnt++;
        @(negedge clk);
        dec_done  = 1'b0;
        req_valid = '0;
        dec_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int ack_n;
        int ack_at;
        logic [NREQ-1:0] ack_val;
        ack_n   = 0;
        ack_at  = -1;
        ack_val = '0;
        do_reset();
        req_valid = 4'b0010;
        req_data[DW +: DW] = 11'h6C3;
        dec_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                ack_n++;
                ack_at    = c;
                ack_val   = req_ack;
                req_valid = '0;
            end
        end
        total_cnt++;
        if (ack_n != 1 || ack_at != 16 || ack_val !== 4'b0010)
            $display("FAIL tmo_ack: got n=%0d at=%0d val=%0h expected n=1 at=16 val=2",
                     ack_n, ack_at, ack_val);
        else pass_cnt++;
        total_cnt++;
        if (tmo_cnt !== 8'd1)
            $display("FAIL tmo_count: got %0d expected 1", tmo_cnt);
        else pass_cnt++;
        dec_done = 1'b1;
        dec_syn  = 3'd3;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (corr_cnt !== 8'd0 || req_ack !== 4'b0000 || busy !== 1'b0)
            $display("FAIL tmo_late_done: got corr=%0d ack=%0h busy=%0h expected 0 0 0",
                     corr_cnt, req_ack, busy);
        else pass_cnt++;
        dec_done = 1'b0;
        dec_syn  = 3'd0;
    endtask

    task automatic test_sat_clear();
        int acks;
        bit got;
        acks = 0;
        do_reset();
        req_valid = 4'b0001;
        req_data[0 +: DW] = 11'h001;
        dec_ready = 1'b1;
        dec_done  = 1'b1;
        dec_syn   = 3'd1;
        for (int c = 0; c < 1000 && acks < 260; c++) begin
            @(negedge clk);
            if (req_ack != '0) acks++;
        end
        total_cnt++;
        if (acks != 260)
            $display("FAIL sat_acks: got %0d expected 260", acks);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (corr_cnt !== 8'd255)
            $display("FAIL sat_corr: got %0d expected 255", corr_cnt);
        else pass_cnt++;
        got = 1'b0;
        for (int w = 0; w < 6 && !got; w++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                got      = 1'b1;
                dec_syn  = 3'd5;
                stat_clr = 1'b1;
            end
        end
        @(negedge clk);
        stat_clr  = 1'b0;
        req_valid = '0;
        dec_done  = 1'b0;
        dec_syn   = 3'd0;
        total_cnt++;
        if (!got || corr_cnt !== 8'd0 || tmo_cnt !== 8'd0)
            $display("FAIL clr_priority: got seen=%0d corr=%0d tmo=%0d expected seen=1 corr=0 tmo=0",
                     got, corr_cnt, tmo_cnt);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int acks;
        acks = 0;
        do_reset();
        req_valid = 4'b1000;
        req_data[3*DW +: DW] = 11'h7FF;
        dec_ready = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || dec_valid !== 1'b0 || grant_id !== 2'd3)
            $display("FAIL mid_wait: got busy=%0h valid=%0h gid=%0h expected 1 0 3",
                     busy, dec_valid, grant_id);
        else pass_cnt++;
        #1;
        rst_n    = 1'b0;
        dec_done = 1'b1;
        #1;
        total_cnt++;
        if (req_ack !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0 || dec_data !== 11'h000)
            $display("FAIL mid_async: got ack=%0h busy=%0h gid=%0h data=%0h expected all 0",
                     req_ack, busy, grant_id, dec_data);
        else pass_cnt++;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (req_ack != '0 || busy) acks++;
        end
        total_cnt++;
        if (acks != 0)
            $display("FAIL mid_after: got %0d cycles with ack/busy expected 0", acks);
        else pass_cnt++;
        dec_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_correction();
        test_backpressure();
        test_timeout();
        test_sat_clear();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
